// File: rtl/spi_temp_reader.sv
// SPI mode-0 read-only master: after an idle gap it clocks one MSB-first frame
// out of the temperature sensor and publishes it with a one-cycle strobe.
module spi_temp_reader #(
    parameter int CLK_DIV     = 2,
    parameter int FRAME_BITS  = 24,
    parameter int IDLE_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  spi_miso,
    output logic                  spi_sclk,
    output logic                  spi_cs_n,
    output logic [FRAME_BITS-1:0] spi_data,
    output logic                  new_data_triger,
    output logic                  busy
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam int GAP_W = $clog2(IDLE_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] data_q, data_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_n_q, cs_n_d;
    logic                  busy_q, busy_d;
    logic                  strobe_q, strobe_d;

    // Next-state logic; output flops are loaded from the next state so they
    // line up with the state they describe.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = data_q;
        sclk_d   = sclk_q;
        strobe_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                sclk_d = 1'b0;
                div_d  = DIV_ZERO;
                bit_d  = BIT_ZERO;
                if (!en) begin
                    gap_d = GAP_ZERO;
                end else if (gap_q == GAP_LAST) begin
                    gap_d   = GAP_ZERO;
                    state_d = S_SETUP;
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end
            S_SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = DIV_ZERO;
                    state_d = S_SHIFT;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            S_SHIFT: begin
                // MISO is captured on the same clk edge that raises SCLK.
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_ONE;
                end else if (!sclk_q) begin
                    div_d   = DIV_ZERO;
                    sclk_d  = 1'b1;
                    shift_d = {shift_q[FRAME_BITS-2:0], spi_miso};
                end else begin
                    div_d  = DIV_ZERO;
                    sclk_d = 1'b0;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = BIT_ZERO;
                        state_d = S_HOLD;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end
            end
            S_HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d    = DIV_ZERO;
                    data_d   = shift_q;
                    strobe_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                sclk_d  = 1'b0;
            end
        endcase
        cs_n_d = !((state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD));
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset aborts any frame and clears the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gap_q    <= GAP_ZERO;
            div_q    <= DIV_ZERO;
            bit_q    <= BIT_ZERO;
            shift_q  <= {FRAME_BITS{1'b0}};
            data_q   <= {FRAME_BITS{1'b0}};
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
        end
    end

    assign spi_sclk        = sclk_q;
    assign spi_cs_n        = cs_n_q;
    assign spi_data        = data_q;
    assign new_data_triger = strobe_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_spi_temp_reader.sv
// Self-checking bench for spi_temp_reader: sensor model driving MISO, a frame
// scoreboard, table-driven frames, reset/enable corner sequences and random words.
module tb_spi_temp_reader;

    localparam int CD = 2;
    localparam int FB = 24;
    localparam int IC = 20;
    localparam int FRAME_LEN = CD * (2 * FB + 2) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          spi_miso;
    logic          spi_sclk;
    logic          spi_cs_n;
    logic [FB-1:0] spi_data;
    logic          new_data_triger;
    logic          busy;

    spi_temp_reader #(.CLK_DIV(CD), .FRAME_BITS(FB), .IDLE_CYCLES(IC)) dut (
        .clk(clk), .rst(rst), .en(en), .spi_miso(spi_miso),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_data(spi_data),
        .new_data_triger(new_data_triger), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sensor: latches a word when CS falls, presents MSB first, advances on SCLK fall.
    logic [FB-1:0] sensor_word = '0;
    logic [FB-1:0] frame_word  = '0;
    int            idx = 0;

    initial begin
        spi_miso = 1'b0;
        forever begin
            @(negedge spi_cs_n);
            frame_word = sensor_word;
            idx = FB - 1;
            spi_miso = frame_word[idx];
        end
    end

    initial begin
        forever begin
            @(negedge spi_sclk);
            if (!spi_cs_n) begin
                if (idx > 0) idx--;
                spi_miso = frame_word[idx];
            end
        end
    end

    // Monitor/scoreboard: every CS fall queues the word the sensor sent;
    // every strobe must deliver the oldest queued word after a full frame.
    logic [FB-1:0] exp_q[$];
    int cyc = 0, cs_fall_cyc = 0, last_strobe_cyc = 0, strobe_gap = 0;
    int frame_rises = 0, idle_run = 0, last_idle_len = 0;
    int cs_falls = 0, n_strobes = 0, total_rises = 0;
    int sclk_viol = 0, strobe_viol = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_strobe = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            frame_rises = 0;
            idle_run = 0;
        end else begin
            if (prev_cs && spi_cs_n && (spi_sclk !== prev_sclk)) sclk_viol++;
            if (prev_strobe && new_data_triger) strobe_viol++;
            if (prev_cs && !spi_cs_n) begin
                cs_falls++;
                cs_fall_cyc = cyc;
                frame_rises = 0;
                last_idle_len = idle_run;
                exp_q.push_back(frame_word);
            end
            if (!prev_sclk && spi_sclk) begin
                frame_rises++;
                total_rises++;
            end
            idle_run = busy ? 0 : idle_run + 1;
            if (new_data_triger) begin
                n_strobes++;
                strobe_gap = cyc - last_strobe_cyc;
                last_strobe_cyc = cyc;
                check("scoreboard_depth", exp_q.size(), 32'd1);
                if (exp_q.size() > 0) check("sb_frame_data", spi_data, exp_q.pop_front());
                check("sclk_rises_per_frame", frame_rises, FB);
                check("frame_length", cyc - cs_fall_cyc + 1, FRAME_LEN);
            end
        end
        prev_cs = spi_cs_n;
        prev_sclk = spi_sclk;
        prev_strobe = new_data_triger;
    end

    task automatic wait_strobe(input int budget);
        int ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (new_data_triger) begin
                ok = 1;
                break;
            end
        end
        #1;
        check("strobe_seen", ok, 32'd1);
    endtask

    typedef struct {
        logic [FB-1:0] word;
        logic [FB-1:0] exp;
        bit            chk_gap;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int n;
        int f0;
        int s0;
        int r0;
        logic [FB-1:0] w;

        tbl[0] = '{24'h006464, 24'h006464, 1'b0};
        tbl[1] = '{24'h000000, 24'h000000, 1'b1};
        tbl[2] = '{24'h004444, 24'h004444, 1'b1};
        tbl[3] = '{24'hAAAAAA, 24'hAAAAAA, 1'b1};

        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cs_n", spi_cs_n, 32'd1);
        check("rst_sclk", spi_sclk, 32'd0);
        check("rst_data", spi_data, 32'd0);
        check("rst_strobe", new_data_triger, 32'd0);
        check("rst_busy", busy, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // en low from reset: link stays quiet
        f0 = cs_falls;
        s0 = n_strobes;
        r0 = total_rises;
        repeat (500) @(negedge clk);
        #1;
        check("en0_cs_falls", cs_falls - f0, 32'd0);
        check("en0_strobes", n_strobes - s0, 32'd0);
        check("en0_sclk_rises", total_rises - r0, 32'd0);
        check("en0_cs_n", spi_cs_n, 32'd1);

        sensor_word = 24'h006464;
        @(negedge clk);
        en = 1'b1;
        n = 0;
        while (spi_cs_n && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("en_to_cs_latency", n, IC);

        for (int i = 0; i < 4; i++) begin
            sensor_word = tbl[i].word;
            wait_strobe(300);
            check("tbl_data", spi_data, tbl[i].exp);
            if (tbl[i].chk_gap) begin
                check("strobe_spacing", strobe_gap, FRAME_LEN + IC);
                check("idle_gap_len", last_idle_len, IC);
            end
        end

        // reset at bit 10 of an all-ones frame
        sensor_word = 24'hFFFFFF;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(!spi_cs_n && frame_rises == 10) && n < 300);
        check("reached_bit10", frame_rises, 32'd10);
        rst = 1'b1;
        #1;
        check("abort_cs_n", spi_cs_n, 32'd1);
        check("abort_sclk", spi_sclk, 32'd0);
        check("abort_data", spi_data, 32'd0);
        check("abort_strobe", new_data_triger, 32'd0);
        check("abort_busy", busy, 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        wait_strobe(300);
        check("after_abort_data", spi_data, 24'hFFFFFF);

        // en dropped mid-frame
        sensor_word = 24'hA5A5A5;
        n = 0;
        while (spi_cs_n && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (30) @(negedge clk);
        en = 1'b0;
        wait_strobe(200);
        check("en_drop_data", spi_data, 24'hA5A5A5);
        f0 = cs_falls;
        repeat (300) @(negedge clk);
        #1;
        check("en_drop_no_new_frame", cs_falls - f0, 32'd0);
        check("en_drop_idle_busy", busy, 32'd0);

        // random words with random enable pauses between frames
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            w = FB'($urandom);
            sensor_word = w;
            wait_strobe(400);
            check("rand_data", spi_data, w);
            if ($urandom_range(0, 1) == 1) begin
                en = 1'b0;
                repeat ($urandom_range(1, 30)) @(negedge clk);
                en = 1'b1;
            end
        end

        check("sclk_quiet_while_cs_high", sclk_viol, 32'd0);
        check("strobe_single_cycle", strobe_viol, 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
